// File: rtl/addsub_pkg.sv
// Shared types and constants for the multicycle adder/subtractor.
// Holds the FSM state encoding and the operation mode values.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/multicycle_adder_subtractor_chunk_adder.sv
// W-bit ripple-carry adder slice.
// Also exposes the carry into the MSB for signed overflow detection.
module chunk_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        logic [W:0] c;
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[W];
        cmsb = c[W - 1];
    end

endmodule

// File: rtl/multicycle_adder_subtractor.sv
// Adder/subtractor that processes CHUNK bits per cycle, LSB slice first.
// Operands shift right each cycle so the slice adder always sees bit 0.
module multicycle_adder_subtractor
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             m_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o,
    output logic             v_o,
    output logic             z_o,
    output logic             n_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             carry_q;

    logic [CHUNK-1:0] sl_sum;
    logic             sl_cout;
    logic             sl_cmsb;
    logic [WIDTH-1:0] s_next;
    logic             sub;

    assign sub     = (m_i == MODE_SUB);
    assign ready_o = rst_ni && (state == IDLE);
    assign valid_o = rst_ni && (state == DONE);

    chunk_adder #(
        .W(CHUNK)
    ) u_chunk (
        .a    (a_q[CHUNK-1:0]),
        .b    (b_q[CHUNK-1:0]),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout),
        .cmsb (sl_cmsb)
    );

    // New slice enters at the top; after NCHUNK shifts s_next is the full result.
    always_comb begin
        s_next = (s_q >> CHUNK) | (WIDTH'(sl_sum) << (WIDTH - CHUNK));
    end

    // Control FSM plus operand, accumulator and result registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            s_o     <= '0;
            c_o     <= 1'b0;
            v_o     <= 1'b0;
            z_o     <= 1'b0;
            n_o     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i ^ {WIDTH{sub}};
                        carry_q <= sub;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    s_q     <= s_next;
                    carry_q <= sl_cout;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        s_o   <= s_next;
                        c_o   <= sl_cout;
                        v_o   <= sl_cout ^ sl_cmsb;
                        z_o   <= (s_next == '0);
                        n_o   <= s_next[WIDTH-1];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/multicycle_adder_subtractor.md
MULTICYCLE_ADDER_SUBTRACTOR -- requirements
Module: multicycle_adder_subtractor

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4, bits processed per cycle; SHALL satisfy 1 <= CHUNK <= WIDTH.
REQ-003 Derived NCHUNK = WIDTH/CHUNK, the number of compute cycles per operation.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 rst_ni  input  1  synchronous active-low reset.
REQ-007 valid_i  input  1  operand request valid.
REQ-008 ready_o  output  1  block can accept an operation.
REQ-009 a_i  input  WIDTH  minuend/augend.
REQ-010 b_i  input  WIDTH  subtrahend/addend.
REQ-011 m_i  input  1  mode; 0 = add (a+b), 1 = subtract (a-b).
REQ-012 valid_o  output  1  result valid.
REQ-013 ready_i  input  1  consumer accepts result.
REQ-014 s_o  output  WIDTH  sum/difference, two's complement.
REQ-015 c_o  output  1  carry out of bit WIDTH-1; in subtract mode, 1 = no borrow (a >= b unsigned).
REQ-016 v_o  output  1  signed overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-017 z_o  output  1  s_o == 0.
REQ-018 n_o  output  1  s_o[WIDTH-1].

Function
REQ-019 The FSM SHALL have states IDLE, RUN and DONE.
REQ-020 ready_o SHALL be 1 only in IDLE while rst_ni is high.
REQ-021 On an edge with valid_i && ready_o, the block SHALL register a_i, b_i XOR {WIDTH{m_i}} and carry-in = m_i, clear the chunk counter and enter RUN.
REQ-022 In RUN, each edge SHALL compute one CHUNK-bit slice, LSB slice first, feeding the slice carry-out into the next slice.
REQ-023 The edge that computes slice NCHUNK-1 SHALL load s_o, c_o, v_o, z_o and n_o, and enter DONE.
REQ-024 valid_o SHALL be 1 exactly in DONE, first asserted NCHUNK edges after the accepting edge.
REQ-025 In DONE, s_o and all flags SHALL be held stable until an edge with ready_i = 1; that edge returns the FSM to IDLE.
REQ-026 No operation SHALL be accepted in the DONE-to-IDLE handoff edge. Minimum issue interval is NCHUNK+2 cycles when ready_i is held at 1.
REQ-027 valid_i in RUN or DONE SHALL be ignored. Changes on a_i, b_i or m_i after acceptance SHALL NOT affect the result.
REQ-028 Result outputs SHALL retain their last values in IDLE and are meaningful only while valid_o = 1.
REQ-029 For NCHUNK = 1, RUN SHALL last exactly one edge; the counter width SHALL be max(1, clog2(NCHUNK)).
REQ-030 Arithmetic SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-031 On an edge with rst_ni = 0, the FSM SHALL go to IDLE and the chunk counter, operand registers, s_o, c_o, v_o, z_o and n_o SHALL clear to 0.
REQ-032 While rst_ni = 0, valid_o and ready_o SHALL be 0.
REQ-033 Reset in RUN or DONE SHALL abandon the operation without producing a result.
REQ-034 ready_o SHALL be 1 in the first cycle after rst_ni returns high.

Structure
REQ-035 Shared package addsub_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the mode constants MODE_ADD = 0 and MODE_SUB = 1.
REQ-036 One sub-module, chunk_adder, SHALL be a parametrised CHUNK-bit ripple adder with carry-in, sum, carry-out and carry-into-MSB outputs. The top SHALL instantiate it once and multiplex slices by the counter.
REQ-037 Shifting operand/result registers or an indexed part-select are both permitted. Either way, the slice multiplexing SHALL stay outside chunk_adder.

Verification (WIDTH = 16, CHUNK = 4 unless stated)
REQ-038 Add 0x1234 + 0x0FFF -> s_o = 0x2233, c_o = 0, v_o = 0, z_o = 0, n_o = 0; valid_o rises exactly 4 edges after acceptance.
REQ-039 Subtract 0x0005 - 0x0007 -> s_o = 0xFFFE, c_o = 0, v_o = 0, n_o = 1. Subtract 0x8000 - 0x0001 -> s_o = 0x7FFF, c_o = 1, v_o = 1.
REQ-040 Add 0x7FFF + 0x0001 -> s_o = 0x8000, v_o = 1, c_o = 0, n_o = 1. Add 0xFFFF + 0x0001 -> s_o = 0x0000, c_o = 1, v_o = 0, z_o = 1.
REQ-041 Hold ready_i = 0 for 5 cycles in DONE and pulse valid_i with new operands during RUN and DONE -> outputs stay stable, ready_o = 0, and the new operands are not accepted.
REQ-042 Assert rst_ni = 0 after 2 RUN edges -> valid_o = 0 with no result emitted; after release, ready_o = 1 and the next add 0x0001 + 0x0001 gives 0x0002.
REQ-043 With CHUNK = 16 (NCHUNK = 1), subtract 0x0000 - 0x0001 -> s_o = 0xFFFF, c_o = 0, v_o = 0, n_o = 1; valid_o rises 1 edge after acceptance.
